mul_seq_param: RTL
==================

Name: mul_seq_param

Overview:
- Parametrised successor to the fixed 32-bit shift-add multiplier for the M-extension MUL group (MUL, MULH, MULHSU, MULHU).
- Sits beside the ALU in EX. Stalls the pipeline while busy and returns a registered result with a one-cycle done pulse.
- Generalised in operand width (XLEN) and bits retired per cycle (BITS_PER_CYCLE).
- Adds a pipeline flush/abort input and registered outputs.

Parameters:
- XLEN, 32: operand width. Legal values are 32 and 64.
- BITS_PER_CYCLE, 2: multiplier bits retired per BUSY cycle. Must divide XLEN; range 1..XLEN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- md_type  in  1  instruction is M-extension.
- md_operation  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx ignored.
- md_flush  in  1  pipeline kill; aborts any operation in flight.
- alu_in1  in  XLEN  rs1.
- alu_in2  in  XLEN  rs2.
- md_result  out  XLEN  registered result; holds until the next done.
- md_alu_stall  out  1  pipeline stall request.
- md_alu_done  out  1  one-cycle pulse; md_result valid in the same cycle.

Behaviour:
- Reset (async assert, sync deassert at clk): state IDLE, md_result=0, md_alu_done=0, md_alu_stall=0, all internal registers cleared. Reset mid-operation drops the operation; no done is produced.
- STEPS = XLEN/BITS_PER_CYCLE. Counter width is clog2(STEPS+1).
- start = (state==IDLE) & md_type & ~md_operation[2] & ~md_flush.
- md_alu_stall = start | (state==BUSY), combinational. It is 0 in DONE.
- IDLE -> BUSY on start. In the start cycle the block latches:
  - opcode;
  - sign flags (MULH: a and b signed; MULHSU: a signed only; MUL and MULHU: unsigned);
  - magnitudes |a| and |b| where the operand is signed and negative. The most-negative value maps to magnitude 2^(XLEN-1) and needs no special case;
  - result_sign = (a_signed & a[XLEN-1]) ^ (b_signed & b[XLEN-1]).
  - product is cleared to 0 and the counter to 0.
- BUSY, each cycle:
  - retire BITS_PER_CYCLE multiplier LSBs;
  - for each set bit, add the shifted multiplicand into the 2*XLEN product;
  - multiplier >>= BITS_PER_CYCLE; multiplicand <<= BITS_PER_CYCLE; counter += 1.
- BUSY -> DONE when the updated counter equals STEPS.
- DONE is a single cycle. md_alu_done=1 and md_result is loaded on the BUSY->DONE edge:
  - MUL: low XLEN bits of the signed-corrected product. This equals the raw low bits since both operands are treated as unsigned.
  - MULH and MULHSU: high XLEN bits of (result_sign ? -product : product).
  - MULHU: high XLEN bits of the raw product.
- DONE -> IDLE unconditionally. A start asserted during DONE is not accepted; the pipeline re-presents it the next cycle.
- Latency, no early-out: start in cycle 0, BUSY cycles 1..STEPS, done in cycle STEPS+1. Default configuration gives done in cycle 17.
- md_flush in BUSY: go to IDLE next edge, no done, md_result unchanged.
- md_flush in DONE: done still pulses; the kill is handled downstream.
- md_flush together with md_type in IDLE: not started, stall=0.
- Operands change during BUSY: ignored, since all values are latched at start.
- md_operation 1xx (DIV group): block stays IDLE and outputs stay at idle values.

Optional Feature:
- Macro: MUL_SEQ_EARLY_OUT_EN.
- When defined: BUSY -> DONE also fires when the shifted multiplier magnitude becomes 0 after the current step, with a minimum of one BUSY cycle. Latency is then 1 + ceil(bitlen(|b|)/BITS_PER_CYCLE) + 1 cycles, with |b|=0 counting as 1 step. Result values are identical.
- When undefined: fixed STEPS+1 latency. The zero-detect logic is not synthesised.

Test Plan:
- MUL 7 x 6, default parameters -> md_result=0x0000002A, done in cycle 17 after start; stall high in cycles 0..16, low in cycle 17.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MUL on the same operands -> 0x00000001.
- Start MUL 3 x 5, assert md_flush in BUSY cycle 5 -> no done, stall low the next cycle, md_result keeps its prior value. Then MUL 2 x 2 -> 0x00000004.
- Assert reset low in BUSY cycle 8 -> stall=0 and done=0 immediately; md_result=0 after release.
- XLEN=64, BITS_PER_CYCLE=4: MULHU 0xFFFFFFFFFFFFFFFF x 2 -> 0x0000000000000001, done in cycle 17. With MUL_SEQ_EARLY_OUT_EN, XLEN=32, BITS_PER_CYCLE=2: MUL 5 x 1 -> 0x00000005, done in cycle 2.

Source files
------------

// File: rtl/mul_seq_param.sv
// Sequential shift-add multiplier for the MUL/MULH/MULHSU/MULHU group, BITS_PER_CYCLE bits per step.
// Optional early completion on an exhausted multiplier: define MUL_SEQ_EARLY_OUT_EN.
module mul_seq_param #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            md_type,
    input  logic [2:0]      md_operation,
    input  logic            md_flush,
    input  logic [XLEN-1:0] alu_in1,
    input  logic [XLEN-1:0] alu_in2,
    output logic [XLEN-1:0] md_result,
    output logic            md_alu_stall,
    output logic            md_alu_done
);

    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_BUSY = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    logic [1:0]        r_state;
    logic [1:0]        r_op;
    logic              r_neg;
    logic [2*XLEN-1:0] r_mcand;
    logic [2*XLEN-1:0] r_prod;
    logic [XLEN-1:0]   r_mplier;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_start;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [2*XLEN-1:0] w_prod_nxt;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [2*XLEN-1:0] w_mcand_nxt;
    logic [XLEN-1:0]   w_mplier_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_last;
    logic [XLEN-1:0]   w_result;

    assign w_start      = (r_state == S_IDLE) & md_type & ~md_operation[2] & ~md_flush;
    assign md_alu_stall = w_start | (r_state == S_BUSY);

    assign w_a_signed = (md_operation[1:0] == OP_MULH) || (md_operation[1:0] == OP_MULHSU);
    assign w_b_signed = (md_operation[1:0] == OP_MULH);
    assign w_neg      = (w_a_signed & alu_in1[XLEN-1]) ^ (w_b_signed & alu_in2[XLEN-1]);
    // Negating the most-negative value yields 2^(XLEN-1) as an unsigned magnitude.
    assign w_a_mag    = (w_a_signed && alu_in1[XLEN-1]) ? -alu_in1 : alu_in1;
    assign w_b_mag    = (w_b_signed && alu_in2[XLEN-1]) ? -alu_in2 : alu_in2;

    always_comb begin
        w_prod_nxt = r_prod;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r_mplier[i]) begin
                w_prod_nxt = w_prod_nxt + (r_mcand << i);
            end
        end
    end

    assign w_mcand_nxt  = r_mcand << BITS_PER_CYCLE;
    assign w_mplier_nxt = r_mplier >> BITS_PER_CYCLE;
    assign w_cnt_nxt    = r_cnt + CNT_W'(1);

`ifdef MUL_SEQ_EARLY_OUT_EN
    assign w_last = (w_cnt_nxt == CNT_W'(STEPS)) || (w_mplier_nxt == '0);
`else
    assign w_last = (w_cnt_nxt == CNT_W'(STEPS));
`endif

    assign w_prod_fix = r_neg ? -w_prod_nxt : w_prod_nxt;

    always_comb begin
        case (r_op)
            OP_MUL:   w_result = w_prod_nxt[XLEN-1:0];
            OP_MULHU: w_result = w_prod_nxt[2*XLEN-1:XLEN];
            default:  w_result = w_prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_op        <= OP_MUL;
            r_neg       <= 1'b0;
            r_mcand     <= '0;
            r_prod      <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
            md_result   <= '0;
            md_alu_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    md_alu_done <= 1'b0;
                    if (w_start) begin
                        r_state  <= S_BUSY;
                        r_op     <= md_operation[1:0];
                        r_neg    <= w_neg;
                        r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_prod   <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_BUSY: begin
                    // A flush abandons the operation even on its final step.
                    if (md_flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_prod   <= w_prod_nxt;
                        r_mcand  <= w_mcand_nxt;
                        r_mplier <= w_mplier_nxt;
                        r_cnt    <= w_cnt_nxt;
                        if (w_last) begin
                            r_state     <= S_DONE;
                            md_alu_done <= 1'b1;
                            md_result   <= w_result;
                        end
                    end
                end
                S_DONE: begin
                    md_alu_done <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    md_alu_done <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
